sirv_uartrx: RTL and testbench

SIRV_UARTRX -- requirements
Module: sirv_uartrx

---
 rtl/sirv_uartrx.sv | 172 +++++++++++++++++
 tb/tb_sirv_uartrx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sirv_uartrx.sv
// sirv_uartrx -- 8N1 UART receiver with 2-flop input synchronizer.
//
// Ports:
//   clock        : single clock, all state updates on its rising edge
//   reset        : synchronous, active-high
//   io_en        : receiver enable; 0 forces IDLE and discards any partial frame
//   io_in        : asynchronous serial line, idle high
//   io_out_valid : one-cycle pulse, received byte available on io_out_bits
//   io_out_bits  : last good received byte, held until the next one
//   io_div       : bit period minus 1, in clocks
//   io_frame_err : one-cycle pulse on a bad stop bit (only with SIRV_UARTRX_FRAMEERR_EN)
//
// Build option: define SIRV_UARTRX_FRAMEERR_EN to add the io_frame_err port.
// Without it, frames with a bad stop bit are dropped silently.
module sirv_uartrx (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_en,
    input  logic        io_in,
    output logic        io_out_valid,
    output logic [7:0]  io_out_bits,
    input  logic [15:0] io_div
`ifdef SIRV_UARTRX_FRAMEERR_EN
    ,
    output logic        io_frame_err
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAITHI
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, rxd_q;
    logic [15:0] prescale_q, prescale_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  bits_q, bits_d;
    logic        valid_q, valid_d;
    logic        tick;
`ifdef SIRV_UARTRX_FRAMEERR_EN
    logic        ferr_q, ferr_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            rxd_q      <= 1'b1;
            prescale_q <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bits_q     <= '0;
            valid_q    <= 1'b0;
`ifdef SIRV_UARTRX_FRAMEERR_EN
            ferr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= io_in;
            rxd_q      <= sync1_q;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bits_q     <= bits_d;
            valid_q    <= valid_d;
`ifdef SIRV_UARTRX_FRAMEERR_EN
            ferr_q     <= ferr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        shift_d    = shift_q;
        bits_d     = bits_q;
        valid_d    = 1'b0;
        tick       = 1'b0;
`ifdef SIRV_UARTRX_FRAMEERR_EN
        ferr_d     = 1'b0;
`endif

        // Bit-period prescaler, only running while a frame is in progress.
        if (state_q inside {ST_START, ST_DATA, ST_STOP}) begin
            if (prescale_q == '0) begin
                tick       = 1'b1;
                prescale_d = io_div;
            end else begin
                prescale_d = prescale_q - 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxd_q) begin
                    if (io_div == '0) begin
                        // With a 1-clock bit the detect cycle already is the start
                        // bit sample; a separate START check would land on data bit 0.
                        state_d    = ST_DATA;
                        count_d    = '0;
                        prescale_d = '0;
                    end else begin
                        state_d    = ST_START;
                        prescale_d = io_div >> 1;
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxd_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        count_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rxd_q, shift_q[7:1]};
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rxd_q) begin
                        bits_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
`ifdef SIRV_UARTRX_FRAMEERR_EN
                        ferr_d  = 1'b1;
`endif
                        state_d = ST_WAITHI;
                    end
                end
            end
            ST_WAITHI: begin
                // A line held low after a bad frame must not start new frames.
                if (rxd_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!io_en) begin
            state_d = ST_IDLE;
            bits_d  = bits_q;
            valid_d = 1'b0;
`ifdef SIRV_UARTRX_FRAMEERR_EN
            ferr_d  = 1'b0;
`endif
        end
    end

    assign io_out_valid = valid_q;
    assign io_out_bits  = bits_q;
`ifdef SIRV_UARTRX_FRAMEERR_EN
    assign io_frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_sirv_uartrx.sv
// tb_sirv_uartrx -- self-checking bench for sirv_uartrx.
// Expected bytes are queued when a good frame is driven and popped by a
// monitor on each io_out_valid pulse.
module tb_sirv_uartrx;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_en;
    logic        io_in;
    logic        io_out_valid;
    logic [7:0]  io_out_bits;
    logic [15:0] io_div;
`ifdef SIRV_UARTRX_FRAMEERR_EN
    logic        io_frame_err;
`endif

    sirv_uartrx dut (
        .clock        (clock),
        .reset        (reset),
        .io_en        (io_en),
        .io_in        (io_in),
        .io_out_valid (io_out_valid),
        .io_out_bits  (io_out_bits),
        .io_div       (io_div)
`ifdef SIRV_UARTRX_FRAMEERR_EN
        ,
        .io_frame_err (io_frame_err)
`endif
    );

    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          last_valid_cyc = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    int          nv0;
    int          nf0;
    logic        prev_valid = 1'b0;
    logic        prev_ferr = 1'b0;
    logic [7:0]  mon_exp;
    logic [7:0]  exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop and pulse-width checks, sampled on the falling edge.
    always @(negedge clock) begin
        if (io_out_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            check_eq("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", {31'd0, io_out_valid}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("rx_byte", {24'd0, io_out_bits}, {24'd0, mon_exp});
            end
        end
        prev_valid = io_out_valid;
`ifdef SIRV_UARTRX_FRAMEERR_EN
        if (io_frame_err === 1'b1) begin
            n_ferr++;
            check_eq("ferr_width", {31'd0, prev_ferr}, 32'd0);
        end
        prev_ferr = io_frame_err;
`endif
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int div);
        io_in = b;
        idle_cycles(div + 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
        t_start = cyc;
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) send_bit(d[i], div);
        send_bit(stop, div);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        reset  = 1'b1;
        io_en  = 1'b0;
        io_in  = 1'b1;
        io_div = 16'd3;
        idle_cycles(3);
        check_eq("rst_bits", {24'd0, io_out_bits}, 32'd0);
        check_eq("rst_valid", {31'd0, io_out_valid}, 32'd0);
`ifdef SIRV_UARTRX_FRAMEERR_EN
        check_eq("rst_ferr", {31'd0, io_frame_err}, 32'd0);
`endif
        reset = 1'b0;
        io_en = 1'b1;
        idle_cycles(4);

        // 0xA5 at io_div=3, latency from io_in edge = 2 sync + (div>>1)+9*(div+1)+2
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 3);
        idle_cycles(8);
        check_eq("lat_a5", last_valid_cyc - t_start, 2 + 1 + 9 * 4 + 2);

        // 2-clock glitch at io_div=15 must be rejected
        io_div = 16'd15;
        idle_cycles(4);
        nv0 = n_valid;
        io_in = 1'b0;
        idle_cycles(2);
        io_in = 1'b1;
        idle_cycles(40);
        check_eq("glitch_nv", n_valid - nv0, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 15);
        idle_cycles(20);
        check_eq("glitch_next_nv", n_valid - nv0, 32'd1);

        // bad stop bit, line held low, then recovery
        io_div = 16'd3;
        idle_cycles(4);
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h3C, 1'b0, 3);
        io_in = 1'b0;
        idle_cycles(20);
        check_eq("badstop_nv", n_valid - nv0, 32'd0);
`ifdef SIRV_UARTRX_FRAMEERR_EN
        check_eq("badstop_ferr", n_ferr - nf0, 32'd1);
`endif
        io_in = 1'b1;
        idle_cycles(8);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 3);
        idle_cycles(12);
        check_eq("badstop_next_nv", n_valid - nv0, 32'd1);

        // io_div=0, back-to-back frames
        io_div = 16'd0;
        idle_cycles(4);
        nv0 = n_valid;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle_cycles(10);
        check_eq("b2b_nv", n_valid - nv0, 32'd2);

        // enable dropped during data bit 4 of 0x55
        io_div = 16'd3;
        idle_cycles(4);
        nv0 = n_valid;
        d = 8'h55;
        send_bit(1'b0, 3);
        for (int i = 0; i < 4; i++) send_bit(d[i], 3);
        io_en = 1'b0;
        for (int i = 4; i < 8; i++) send_bit(d[i], 3);
        send_bit(1'b1, 3);
        idle_cycles(8);
        check_eq("endrop_nv", n_valid - nv0, 32'd0);
        io_en = 1'b1;
        idle_cycles(8);
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, 3);
        idle_cycles(12);
        check_eq("endrop_next_nv", n_valid - nv0, 32'd1);

        // reset asserted during data of 0x77 and held to the end of that frame
        nv0 = n_valid;
        d = 8'h77;
        send_bit(1'b0, 3);
        for (int i = 0; i < 4; i++) send_bit(d[i], 3);
        reset = 1'b1;
        for (int i = 4; i < 8; i++) send_bit(d[i], 3);
        send_bit(1'b1, 3);
        check_eq("midrst_bits", {24'd0, io_out_bits}, 32'd0);
        check_eq("midrst_valid", {31'd0, io_out_valid}, 32'd0);
`ifdef SIRV_UARTRX_FRAMEERR_EN
        check_eq("midrst_ferr", {31'd0, io_frame_err}, 32'd0);
`endif
        reset = 1'b0;
        idle_cycles(8);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 3);
        idle_cycles(12);
        check_eq("midrst_next_nv", n_valid - nv0, 32'd1);

        check_eq("sb_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
